recover_ctrl: RTL and testbench

Sequences precise-state recovery after a mispredicted branch retires from the ROB. It gates which retire slots commit into the architectural table, then runs a fixed squash → restore → drain sequence. During that sequence it pulses the pipeline flush and loads the map table and free list from architectural state. It stalls dispatch until the back end is quiet. It sits beside the ROB retire port, between the arch table, map table, free list and fetch redirect logic.

---
 rtl/recover_ctrl.sv | 111 +++++++++++
 tb/tb_recover_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/recover_ctrl.sv
// Branch-mispredict recovery sequencer: gates retire commits, then steps through SQUASH -> RESTORE -> DRAIN.
// Optional feature: define RECOVER_PERF_CNT_EN to add the recover_count_o recovery counter.
module recover_ctrl #(
    parameter int TABLE_WRITE  = 2,
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [TABLE_WRITE-1:0]              retire_en_i,
    input  logic [TABLE_WRITE-1:0]              branch_recover_i,
    input  logic [TABLE_WRITE-1:0][XLEN-1:0]    recover_pc_i,
    input  logic                                fu_busy_i,
    output logic [TABLE_WRITE-1:0]              retire_mask_o,
    output logic                                squash_o,
    output logic                                redirect_valid_o,
    output logic [XLEN-1:0]                     redirect_pc_o,
    output logic                                map_restore_o,
    output logic                                freelist_restore_o,
    output logic                                dispatch_stall_o,
`ifdef RECOVER_PERF_CNT_EN
    output logic [31:0]                         recover_count_o,
`endif
    output logic                                busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SQUASH  = 2'd1,
        RESTORE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t                   state, state_nxt;
    logic [3:0]               drain_cnt, drain_cnt_nxt;
    logic [XLEN-1:0]          redirect_pc_q;
    logic                     hit;
    logic [XLEN-1:0]          hit_pc;
    logic [TABLE_WRITE-1:0]   idle_mask;

    // Lowest recovering slot wins; slots above it are kept out of the arch table.
    always_comb begin
        hit       = 1'b0;
        hit_pc    = '0;
        idle_mask = '0;
        for (int j = 0; j < TABLE_WRITE; j++) begin
            idle_mask[j] = retire_en_i[j] & ~hit;
            if (!hit && retire_en_i[j] && branch_recover_i[j]) begin
                hit    = 1'b1;
                hit_pc = recover_pc_i[j];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        unique case (state)
            IDLE:    if (hit) state_nxt = SQUASH;
            SQUASH:  state_nxt = RESTORE;
            RESTORE: begin
                state_nxt     = DRAIN;
                drain_cnt_nxt = DRAIN_LOAD;
            end
            DRAIN: begin
                if (drain_cnt != 4'd0) drain_cnt_nxt = drain_cnt - 4'd1;
                if (drain_cnt == 4'd0 && !fu_busy_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            drain_cnt     <= 4'd0;
            redirect_pc_q <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (state == IDLE && hit) redirect_pc_q <= hit_pc;
        end
    end

`ifdef RECOVER_PERF_CNT_EN
    logic [31:0] recover_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recover_count_q <= 32'd0;
        end else if (state == IDLE && hit && recover_count_q != 32'hFFFF_FFFF) begin
            recover_count_q <= recover_count_q + 32'd1;
        end
    end

    assign recover_count_o = recover_count_q;
`endif

    // Strobes come straight off the state register so no input reaches them combinationally.
    assign retire_mask_o      = (state == IDLE) ? idle_mask : '0;
    assign squash_o           = (state == SQUASH);
    assign redirect_valid_o   = (state == SQUASH);
    assign redirect_pc_o      = redirect_pc_q;
    assign map_restore_o      = (state == RESTORE);
    assign freelist_restore_o = (state == RESTORE);
    assign dispatch_stall_o   = (state != IDLE);
    assign busy_o             = (state != IDLE);

endmodule

// File: tb/tb_recover_ctrl.sv
// Directed self-checking bench for recover_ctrl (TABLE_WRITE=2, XLEN=32, DRAIN_CYCLES=3).
module tb_recover_ctrl;

    logic              clk;
    logic              reset;
    logic [1:0]        retire_en_i;
    logic [1:0]        branch_recover_i;
    logic [1:0][31:0]  recover_pc_i;
    logic              fu_busy_i;
    logic [1:0]        retire_mask_o;
    logic              squash_o;
    logic              redirect_valid_o;
    logic [31:0]       redirect_pc_o;
    logic              map_restore_o;
    logic              freelist_restore_o;
    logic              dispatch_stall_o;
    logic              busy_o;
`ifdef RECOVER_PERF_CNT_EN
    logic [31:0]       recover_count_o;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    recover_ctrl #(.TABLE_WRITE(2), .XLEN(32), .DRAIN_CYCLES(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .retire_en_i        (retire_en_i),
        .branch_recover_i   (branch_recover_i),
        .recover_pc_i       (recover_pc_i),
        .fu_busy_i          (fu_busy_i),
        .retire_mask_o      (retire_mask_o),
        .squash_o           (squash_o),
        .redirect_valid_o   (redirect_valid_o),
        .redirect_pc_o      (redirect_pc_o),
        .map_restore_o      (map_restore_o),
        .freelist_restore_o (freelist_restore_o),
        .dispatch_stall_o   (dispatch_stall_o),
`ifdef RECOVER_PERF_CNT_EN
        .recover_count_o    (recover_count_o),
`endif
        .busy_o             (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        retire_en_i      = 2'b00;
        branch_recover_i = 2'b00;
        recover_pc_i[0]  = 32'h0;
        recover_pc_i[1]  = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        fu_busy_i = 1'b0;
        idle_inputs();
        retire_en_i = 2'b10;
        #3;
        chk("rst_mask_follows_en", 64'(retire_mask_o), 64'h2);
        chk("rst_squash", 64'(squash_o), 64'h0);
        chk("rst_redirect_pc", 64'(redirect_pc_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_stall", 64'(dispatch_stall_o), 64'h0);
        tick();
        tick();
        reset = 1'b0;
        idle_inputs();

        // No-hit cases stay in IDLE with the full retire mask.
        retire_en_i = 2'b11; branch_recover_i = 2'b00;
        #1 chk("nohit_mask", 64'(retire_mask_o), 64'h3);
        tick();
        retire_en_i = 2'b01; branch_recover_i = 2'b10;
        #1 chk("nonretire_recover_mask", 64'(retire_mask_o), 64'h1);
        chk("nohit_busy", 64'(busy_o), 64'h0);
        tick();
        chk("nohit_still_idle", 64'(busy_o), 64'h0);

        // Single recovery in slot 0 (cycle T).
        retire_en_i = 2'b11; branch_recover_i = 2'b01;
        recover_pc_i[0] = 32'h0000_1040; recover_pc_i[1] = 32'hDEAD_BEEF;
        #1 chk("t0_mask", 64'(retire_mask_o), 64'h1);
        chk("t0_squash_low", 64'(squash_o), 64'h0);
        tick();
        idle_inputs();
        #1;
        chk("t1_squash", 64'(squash_o), 64'h1);
        chk("t1_redirect_valid", 64'(redirect_valid_o), 64'h1);
        chk("t1_redirect_pc", 64'(redirect_pc_o), 64'h1040);
        chk("t1_map_low", 64'(map_restore_o), 64'h0);
        chk("t1_stall", 64'(dispatch_stall_o), 64'h1);
        tick();
        chk("t2_squash_low", 64'(squash_o), 64'h0);
        chk("t2_map_restore", 64'(map_restore_o), 64'h1);
        chk("t2_freelist_restore", 64'(freelist_restore_o), 64'h1);
        tick();
        chk("t3_map_low", 64'(map_restore_o), 64'h0);
        chk("t3_busy", 64'(busy_o), 64'h1);
        tick();
        retire_en_i = 2'b11; branch_recover_i = 2'b01; recover_pc_i[0] = 32'h0000_7777;
        #1 chk("t4_drain_mask_zero", 64'(retire_mask_o), 64'h0);
        chk("t4_busy", 64'(busy_o), 64'h1);
        tick();
        idle_inputs();
        #1 chk("t5_busy", 64'(busy_o), 64'h1);
        chk("t5_no_new_squash", 64'(squash_o), 64'h0);
        tick();
        chk("t6_busy_low", 64'(busy_o), 64'h0);
        chk("t6_stall_low", 64'(dispatch_stall_o), 64'h0);
        chk("t6_redirect_pc_kept", 64'(redirect_pc_o), 64'h1040);
`ifdef RECOVER_PERF_CNT_EN
        chk("t6_count_one", 64'(recover_count_o), 64'h1);
`endif

        // Slot-1 recovery issued in the first IDLE cycle, then an extended drain.
        retire_en_i = 2'b11; branch_recover_i = 2'b10;
        recover_pc_i[0] = 32'h0000_0500; recover_pc_i[1] = 32'h0000_2220;
        #1 chk("s1_mask", 64'(retire_mask_o), 64'h3);
        tick();
        idle_inputs();
        fu_busy_i = 1'b1;
        #1 chk("s1_squash", 64'(squash_o), 64'h1);
        chk("s1_redirect_pc", 64'(redirect_pc_o), 64'h2220);
        tick();
        chk("s1_restore", 64'(map_restore_o), 64'h1);
        for (int c = 3; c <= 8; c++) begin
            tick();
            chk($sformatf("ext_drain_busy_t%0d", c), 64'(busy_o), 64'h1);
            chk($sformatf("ext_drain_stall_t%0d", c), 64'(dispatch_stall_o), 64'h1);
        end
        tick();
        fu_busy_i = 1'b0;
        #1 chk("ext_t9_busy", 64'(busy_o), 64'h1);
        tick();
        chk("ext_t10_idle", 64'(busy_o), 64'h0);

        // Both slots recover: lowest wins; then reset lands mid-RESTORE.
        retire_en_i = 2'b11; branch_recover_i = 2'b11;
        recover_pc_i[0] = 32'h0000_0100; recover_pc_i[1] = 32'h0000_0200;
        #1 chk("both_mask", 64'(retire_mask_o), 64'h1);
        tick();
        idle_inputs();
        #1 chk("both_redirect_pc", 64'(redirect_pc_o), 64'h100);
        tick();
        chk("pre_reset_map", 64'(map_restore_o), 64'h1);
        reset = 1'b1;
        #1;
        chk("async_reset_map_drop", 64'(map_restore_o), 64'h0);
        chk("async_reset_freelist_drop", 64'(freelist_restore_o), 64'h0);
        chk("async_reset_busy", 64'(busy_o), 64'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_busy", 64'(busy_o), 64'h0);
        chk("post_reset_redirect_pc", 64'(redirect_pc_o), 64'h0);
`ifdef RECOVER_PERF_CNT_EN
        chk("post_reset_count", 64'(recover_count_o), 64'h0);
`endif
        tick();
        chk("post_reset_still_idle", 64'(squash_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
